// File: rtl/response_arbiter.sv
// response_arbiter: round-robin return-path arbiter sequencing two-byte responses through a shared UART TX
module response_arbiter #(
  parameter int N_IF       = 4,
  parameter int TX_TIMEOUT = 100000,
  parameter int TMR_W      = 17
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic [N_IF-1:0]   i_Resp_Valid,
  input  logic [8*N_IF-1:0] i_Resp_Code,
  input  logic [8*N_IF-1:0] i_Resp_Data,
  output logic [N_IF-1:0]   o_Resp_Ack,
  output logic              o_Tx_Start,
  output logic [7:0]        o_Tx_Byte,
  input  logic              i_Tx_Active,
  input  logic              i_Tx_Done,
  output logic              o_Busy,
  output logic              o_Sent,
  output logic              o_Error
);
  localparam int PW = N_IF > 1 ? $clog2(N_IF) : 1;
  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TX_TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, SEND_CODE, WAIT_CODE, SEND_DATA, WAIT_DATA} state_t;
  state_t state;
  logic [PW-1:0] ptr, grant;
  logic [TMR_W-1:0] timer;
  logic [7:0] code, data;
  function automatic logic [PW-1:0] wrap(input int k);
    return PW'(k >= N_IF ? k - N_IF : k);
  endfunction
  // first pending requester at or after ptr, wrapping; scanned backwards so the nearest one wins
  always_comb begin
    grant = ptr;
    for (int i = N_IF - 1; i >= 0; i--)
      if (i_Resp_Valid[wrap(int'(ptr) + i)]) grant = wrap(int'(ptr) + i);
  end
  // arbitration and two-byte TX sequencing with per-byte done timeout; all outputs registered
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state      <= IDLE;
      ptr        <= '0;
      timer      <= '0;
      code       <= '0;
      data       <= '0;
      o_Resp_Ack <= '0;
      o_Tx_Start <= 1'b0;
      o_Tx_Byte  <= 8'h00;
      o_Busy     <= 1'b0;
      o_Sent     <= 1'b0;
      o_Error    <= 1'b0;
    end else begin
      o_Resp_Ack <= '0;
      o_Tx_Start <= 1'b0;
      o_Sent     <= 1'b0;
      o_Error    <= 1'b0;
      case (state)
        IDLE:
          if (|i_Resp_Valid) begin
            code       <= i_Resp_Code[8*grant +: 8];
            data       <= i_Resp_Data[8*grant +: 8];
            o_Resp_Ack <= N_IF'(1) << grant;
            ptr        <= wrap(int'(grant) + 1);
            state      <= SEND_CODE;
            o_Busy     <= 1'b1;
          end
        SEND_CODE, SEND_DATA:
          if (!i_Tx_Active) begin
            o_Tx_Byte  <= state == SEND_CODE ? code : data;
            o_Tx_Start <= 1'b1;
            timer      <= '0;
            state      <= state == SEND_CODE ? WAIT_CODE : WAIT_DATA;
          end
        WAIT_CODE, WAIT_DATA:
          if (i_Tx_Done) begin
            o_Sent <= state == WAIT_DATA;
            o_Busy <= state == WAIT_CODE;
            state  <= state == WAIT_CODE ? SEND_DATA : IDLE;
          end else if (timer == LIMIT) begin
            o_Error <= 1'b1;
            o_Busy  <= 1'b0;
            state   <= IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        default: begin
          state  <= IDLE;
          o_Busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_response_arbiter.sv
// tb_response_arbiter: directed table-driven bench for response_arbiter with a simple TX model
module tb_response_arbiter;
  logic        clk;
  logic        i_Reset;
  logic [3:0]  i_Resp_Valid;
  logic [31:0] i_Resp_Code;
  logic [31:0] i_Resp_Data;
  logic [3:0]  o_Resp_Ack;
  logic        o_Tx_Start;
  logic [7:0]  o_Tx_Byte;
  logic        i_Tx_Active;
  logic        i_Tx_Done;
  logic        o_Busy;
  logic        o_Sent;
  logic        o_Error;
  response_arbiter #(.N_IF(4), .TX_TIMEOUT(16), .TMR_W(5)) dut (
    .i_Clock(clk), .i_Reset(i_Reset), .i_Resp_Valid(i_Resp_Valid),
    .i_Resp_Code(i_Resp_Code), .i_Resp_Data(i_Resp_Data), .o_Resp_Ack(o_Resp_Ack),
    .o_Tx_Start(o_Tx_Start), .o_Tx_Byte(o_Tx_Byte), .i_Tx_Active(i_Tx_Active),
    .i_Tx_Done(i_Tx_Done), .o_Busy(o_Busy), .o_Sent(o_Sent), .o_Error(o_Error)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] valid;
    int         grant;
    int         hold;
  } vec_t;
  vec_t vecs[8];
  int tests = 0, fails = 0;
  int cyc = 0, sent_cnt = 0, err_cnt = 0, ack_cnt = 0;
  int start_cyc = 0, err_cyc = 0;
  int tx_cnt = 0;
  bit tx_busy = 0, tx_hang = 0, hold_active = 0;
  logic [7:0] tx_bytes[$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    i_Tx_Done = 1'b0;
    if (tx_busy && !tx_hang) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        i_Tx_Done = 1'b1;
        tx_busy = 0;
      end
    end
    if (o_Tx_Start) begin
      tx_busy = 1;
      tx_cnt = 10;
      start_cyc = cyc;
      tx_bytes.push_back(o_Tx_Byte);
    end
    i_Tx_Active = tx_busy | hold_active;
    if (o_Sent) sent_cnt++;
    if (o_Error) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (|o_Resp_Ack) begin
      ack_cnt++;
      check("ack_onehot", 32'($countones(o_Resp_Ack)), 32'd1);
    end
  endtask
  function automatic logic [7:0] code_of(input int g);
    return i_Resp_Code[8*g +: 8];
  endfunction
  function automatic logic [7:0] data_of(input int g);
    return i_Resp_Data[8*g +: 8];
  endfunction
  task automatic run_txn(input logic [3:0] v, input int g, input int hold, input bit drop);
    int sent0, acks0;
    sent0 = sent_cnt;
    acks0 = ack_cnt;
    tx_bytes.delete();
    hold_active = hold > 0;
    i_Tx_Active = tx_busy | hold_active;
    i_Resp_Valid = v;
    step();
    check("ack_grant", 32'(o_Resp_Ack), 32'(4'b0001 << g));
    if (drop) i_Resp_Valid[g] = 1'b0;
    for (int k = 0; k < hold; k++) begin
      step();
      check("start_held", 32'(o_Tx_Start), 32'd0);
    end
    hold_active = 0;
    i_Tx_Active = tx_busy;
    step();
    check("first_start", 32'(o_Tx_Start), 32'd1);
    for (int k = 0; k < 60 && sent_cnt == sent0; k++) step();
    check("sent_pulse", 32'(sent_cnt - sent0), 32'd1);
    check("busy_done", 32'(o_Busy), 32'd0);
    check("ack_count", 32'(ack_cnt - acks0), 32'd1);
    check("byte_count", 32'(tx_bytes.size()), 32'd2);
    if (tx_bytes.size() == 2) begin
      check("code_byte", 32'(tx_bytes[0]), 32'(code_of(g)));
      check("data_byte", 32'(tx_bytes[1]), 32'(data_of(g)));
    end
    if (drop) i_Resp_Valid = 4'b0000;
  endtask
  initial begin
    int sent0, err0, s;
    i_Resp_Code = {8'h93, 8'h72, 8'hA1, 8'h50};
    i_Resp_Data = {8'h39, 8'h27, 8'h3C, 8'h05};
    vecs[0] = '{4'b0010, 1, 0};
    vecs[1] = '{4'b1001, 3, 0};
    vecs[2] = '{4'b1001, 0, 0};
    vecs[3] = '{4'b0100, 2, 5};
    vecs[4] = '{4'b0011, 0, 0};
    vecs[5] = '{4'b1000, 3, 0};
    vecs[6] = '{4'b1111, 0, 0};
    vecs[7] = '{4'b1110, 1, 0};
    i_Reset = 1'b1;
    i_Resp_Valid = 4'b0000;
    i_Tx_Active = 1'b0;
    i_Tx_Done = 1'b0;
    repeat (3) step();
    check("rst_busy", 32'(o_Busy), 32'd0);
    check("rst_ack", 32'(o_Resp_Ack), 32'd0);
    check("rst_start", 32'(o_Tx_Start), 32'd0);
    check("rst_byte", 32'(o_Tx_Byte), 32'd0);
    check("rst_sent", 32'(o_Sent), 32'd0);
    check("rst_error", 32'(o_Error), 32'd0);
    i_Reset = 1'b0;
    for (int k = 0; k < 5; k++) run_txn(4'b1111, k % 4, 0, 0);
    i_Resp_Valid = 4'b0000;
    foreach (vecs[i]) run_txn(vecs[i].valid, vecs[i].grant, vecs[i].hold, 1);
    tx_hang = 1;
    tx_bytes.delete();
    sent0 = sent_cnt;
    err0 = err_cnt;
    i_Resp_Valid = 4'b0100;
    step();
    check("to_ack", 32'(o_Resp_Ack), 32'b0100);
    i_Resp_Valid = 4'b0000;
    step();
    check("to_start", 32'(o_Tx_Start), 32'd1);
    s = start_cyc;
    for (int k = 0; k < 40 && err_cnt == err0; k++) step();
    check("to_error_seen", 32'(err_cnt - err0), 32'd1);
    check("to_error_delay", 32'(err_cyc - s), 32'd16);
    check("to_busy", 32'(o_Busy), 32'd0);
    repeat (5) step();
    check("to_error_once", 32'(err_cnt - err0), 32'd1);
    check("to_no_data", 32'(tx_bytes.size()), 32'd1);
    check("to_no_sent", 32'(sent_cnt - sent0), 32'd0);
    tx_hang = 0;
    tx_busy = 0;
    i_Tx_Active = 1'b0;
    tx_bytes.delete();
    sent0 = sent_cnt;
    err0 = err_cnt;
    i_Resp_Valid = 4'b0100;
    step();
    check("rs_ack", 32'(o_Resp_Ack), 32'b0100);
    i_Resp_Valid = 4'b0000;
    for (int k = 0; k < 60 && tx_bytes.size() < 2; k++) step();
    check("rs_data_start", 32'(tx_bytes.size()), 32'd2);
    repeat (2) step();
    i_Reset = 1'b1;
    step();
    check("rs_busy", 32'(o_Busy), 32'd0);
    check("rs_start", 32'(o_Tx_Start), 32'd0);
    check("rs_byte", 32'(o_Tx_Byte), 32'd0);
    check("rs_ack0", 32'(o_Resp_Ack), 32'd0);
    check("rs_sent", 32'(o_Sent), 32'd0);
    check("rs_error", 32'(o_Error), 32'd0);
    i_Reset = 1'b0;
    tx_busy = 0;
    i_Tx_Active = 1'b0;
    repeat (20) step();
    check("rs_no_sent", 32'(sent_cnt - sent0), 32'd0);
    check("rs_no_error", 32'(err_cnt - err0), 32'd0);
    run_txn(4'b1111, 0, 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
